csi2tx_lane_pkt_scheduler: RTL and testbench
============================================

// Module: csi2tx_lane_pkt_scheduler
// PURPOSE
//  Packet-level scheduler in front of the lane distribution layers (1..8 lane LDLs).
//  Arbitrates round-robin between NUM_REQ packet sources (per-source byte FIFOs).
//  Latches the lane configuration per packet and drives the one-hot LDL enable and enable_hs_transmission.
//  Enforces a programmable inter-packet gap and a per-packet timeout abort.
// PARAMETERS
//  NUM_REQ   4   number of packet sources (2..8)
//  GAP_W     8   width of gap_cfg
//  TO_W      16  width of timeout_cfg / timeout counter
// PORTS
//  txbyteclkhs             in   1        byte clock; single clock domain
//  txbyteclkhs_rst         in   1        synchronous, active-high reset
//  tinit_start             in   1        PHY init complete; no new packet starts while low
//  forcetxstopmode         in   1        global stop; aborts the schedule without error
//  req_fifo_empty          in   NUM_REQ  per-source FIFO empty; request = ~req_fifo_empty[i]
//  lane_cfg                in   3        active lanes minus 1 (0=1 lane .. 7=8 lanes)
//  gap_cfg                 in   GAP_W    idle cycles between packets
//  timeout_cfg             in   TO_W     max cycles per packet; 0 disables the timeout
//  ldl_tx_done             in   1        level from the active LDL (high in its STOP_STATE)
//  ldl_idle                in   1        active LDL back in IDLE
//  grant                   out  NUM_REQ  one-hot source select for FIFO read/data muxing
//  lane_en                 out  8        one-hot; lane_en[k] enables the (k+1)-lane LDL
//  enable_hs_transmission  out  1        start/permit of an HS packet on the enabled LDL
//  ldl_force_stop          out  1        forcetxstopmode toward the LDLs during abort
//  timeout_err             out  1        1-cycle pulse on timeout abort
//  sched_busy              out  1        high in every state except IDLE
//  pkt_cnt                 out  16       packets completed; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0, pkt_cnt=0, counters=0.
//  FSM states: IDLE, ARB, ACTIVE, DRAIN, ABORT, GAP.
//  - IDLE: any request && tinit_start && !forcetxstopmode -> ARB.
//  - ARB (1 cycle): winner = first requester searching rr_ptr+1 upward, wrapping.
//    No requester -> IDLE. Else register grant=onehot(winner), rr_ptr=winner,
//    lane_en=onehot(lane_cfg), enable_hs_transmission=1, then -> ACTIVE.
//    Latency: request seen in IDLE at cycle n -> grant/enable visible at cycle n+2.
//  - ACTIVE: enable_hs_transmission=1. On the rising edge of ldl_tx_done
//    (registered previous value, 0->1) -> DRAIN. A stale high level is not an edge.
//  - DRAIN: enable_hs_transmission=0, grant/lane_en held. ldl_idle=1 -> pkt_cnt+1.
//    Then, if gap_cfg==0, -> IDLE; else -> GAP.
//  - Timeout: to_cnt clears on ARB exit and counts in ACTIVE/DRAIN. When
//    timeout_cfg!=0 and to_cnt==timeout_cfg-1: -> ABORT, timeout_err pulses 1 cycle.
//    The timeout takes priority over a same-cycle done edge or ldl_idle.
//  - ABORT: ldl_force_stop=1, enable_hs_transmission=0. On ldl_idle=1 ->
//    ldl_force_stop=0, pkt_cnt unchanged, -> GAP (or IDLE if gap_cfg==0).
//  - GAP: grant=0, lane_en=0. gap_cnt counts from 0 and at gap_cfg-1 -> IDLE.
//    Exactly gap_cfg cycles are spent in GAP.
//  - forcetxstopmode=1 or tinit_start=0 in any state: next state is IDLE.
//    grant, lane_en, enable_hs_transmission and ldl_force_stop clear; counters clear.
//    No timeout_err and no pkt_cnt increment. rr_ptr is kept.
//  - lane_cfg, gap_cfg and timeout_cfg changes after sampling do not affect the
//    packet in flight. gap_cfg is sampled on GAP entry.
//  - A source whose FIFO goes empty while granted keeps its grant until DRAIN/ABORT completes.
//  - Invariant: grant and lane_en are both zero or both one-hot. They are never
//    non-zero in IDLE/ARB/GAP.
// TESTING
//  1 reset, tinit_start=1, src0 requests, lane_cfg=2 -> grant=0001 and lane_en=0000_0100 at n+2.
//    ldl_tx_done then ldl_idle -> pkt_cnt=1.
//  2 all 4 sources requesting continuously, gap_cfg=3 -> grant order 0,1,2,3,0.
//    Exactly 3 cycles with grant=0 between packets.
//  3 timeout_cfg=10, LDL never asserts done -> timeout_err pulses 10 cycles after
//    ACTIVE entry. ldl_force_stop stays high until ldl_idle; pkt_cnt unchanged.
//  4 forcetxstopmode pulse in ACTIVE -> next cycle IDLE, all outputs 0.
//    Next grant goes to rr_ptr+1.
//  5 ldl_tx_done held high across IDLE->ACTIVE -> no DRAIN until it falls and rises again.
//    lane_cfg changed mid-packet -> lane_en unchanged.
//  6 pkt_cnt preloaded via 65535 packets (or forced) -> wraps to 0.
//    gap_cfg=0 -> DRAIN goes directly to IDLE.

Source files
------------

// File: rtl/csi2tx_lane_pkt_scheduler.sv
// csi2tx_lane_pkt_scheduler: round-robin packet scheduler in front of the 1..8 lane LDLs.
// Latches lane/timeout settings per packet, drives HS enable, inter-packet gap and timeout abort.
module csi2tx_lane_pkt_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int GAP_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               txbyteclkhs,
  input  logic               txbyteclkhs_rst,
  input  logic               tinit_start,
  input  logic               forcetxstopmode,
  input  logic [NUM_REQ-1:0] req_fifo_empty,
  input  logic [2:0]         lane_cfg,
  input  logic [GAP_W-1:0]   gap_cfg,
  input  logic [TO_W-1:0]    timeout_cfg,
  input  logic               ldl_tx_done,
  input  logic               ldl_idle,
  output logic [NUM_REQ-1:0] grant,
  output logic [7:0]         lane_en,
  output logic               enable_hs_transmission,
  output logic               ldl_force_stop,
  output logic               timeout_err,
  output logic               sched_busy,
  output logic [15:0]        pkt_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARB    = 3'd1;
  localparam logic [2:0] ACTIVE = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] ABORT  = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         lane_en_q, lane_en_d;
  logic               en_hs_q, en_hs_d;
  logic               force_stop_q, force_stop_d;
  logic               to_err_q, to_err_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]    to_cfg_q, to_cfg_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic               done_prev_q;

  logic [NUM_REQ-1:0] req;
  logic               stop;
  logic               done_rise;
  logic               to_hit;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   cand;
  logic [2:0]         post_state;

  assign req        = ~req_fifo_empty;
  assign stop       = forcetxstopmode | ~tinit_start;
  assign done_rise  = ldl_tx_done & ~done_prev_q;
  assign to_hit     = (to_cfg_q != '0) && (to_cnt_q == to_cfg_q - TO_W'(1));
  assign post_state = (gap_cfg == '0) ? IDLE : GAP;

  // Round-robin search starts one past the last winner and wraps.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    lane_en_d    = lane_en_q;
    en_hs_d      = en_hs_q;
    force_stop_d = force_stop_q;
    to_err_d     = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;
    to_cnt_d     = to_cnt_q;
    to_cfg_d     = to_cfg_q;
    gap_cnt_d    = gap_cnt_q;
    gap_len_d    = gap_len_q;
    if (stop) begin
      // Global stop or lost PHY init: silent return to IDLE, arbitration history kept.
      state_d      = IDLE;
      grant_d      = '0;
      lane_en_d    = '0;
      en_hs_d      = 1'b0;
      force_stop_d = 1'b0;
      to_cnt_d     = '0;
      gap_cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) state_d = ARB;
        end
        ARB: begin
          if (!found) begin
            state_d = IDLE;
          end else begin
            grant_d   = NUM_REQ'(1) << winner;
            rr_ptr_d  = winner;
            lane_en_d = 8'd1 << lane_cfg;
            en_hs_d   = 1'b1;
            to_cnt_d  = '0;
            to_cfg_d  = timeout_cfg;
            state_d   = ACTIVE;
          end
        end
        ACTIVE: begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_hit) begin
            state_d      = ABORT;
            to_err_d     = 1'b1;
            force_stop_d = 1'b1;
            en_hs_d      = 1'b0;
          end else if (done_rise) begin
            state_d = DRAIN;
            en_hs_d = 1'b0;
          end
        end
        DRAIN: begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_hit) begin
            state_d      = ABORT;
            to_err_d     = 1'b1;
            force_stop_d = 1'b1;
          end else if (ldl_idle) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            grant_d   = '0;
            lane_en_d = '0;
            gap_len_d = gap_cfg;
            gap_cnt_d = '0;
            state_d   = post_state;
          end
        end
        ABORT: begin
          if (ldl_idle) begin
            force_stop_d = 1'b0;
            grant_d      = '0;
            lane_en_d    = '0;
            gap_len_d    = gap_cfg;
            gap_cnt_d    = '0;
            state_d      = post_state;
          end
        end
        GAP: begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == gap_len_q - GAP_W'(1)) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          grant_d   = '0;
          lane_en_d = '0;
          en_hs_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge txbyteclkhs) begin
    if (txbyteclkhs_rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= PTR_W'(NUM_REQ - 1);
      grant_q      <= '0;
      lane_en_q    <= '0;
      en_hs_q      <= 1'b0;
      force_stop_q <= 1'b0;
      to_err_q     <= 1'b0;
      pkt_cnt_q    <= '0;
      to_cnt_q     <= '0;
      to_cfg_q     <= '0;
      gap_cnt_q    <= '0;
      gap_len_q    <= '0;
      done_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      lane_en_q    <= lane_en_d;
      en_hs_q      <= en_hs_d;
      force_stop_q <= force_stop_d;
      to_err_q     <= to_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
      to_cnt_q     <= to_cnt_d;
      to_cfg_q     <= to_cfg_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_len_q    <= gap_len_d;
      done_prev_q  <= ldl_tx_done;
    end
  end

  assign grant                  = grant_q;
  assign lane_en                = lane_en_q;
  assign enable_hs_transmission = en_hs_q;
  assign ldl_force_stop         = force_stop_q;
  assign timeout_err            = to_err_q;
  assign sched_busy             = (state_q != IDLE);
  assign pkt_cnt                = pkt_cnt_q;
endmodule

// File: tb/tb_csi2tx_lane_pkt_scheduler.sv
// Directed-plus-random bench for csi2tx_lane_pkt_scheduler against a transaction-level model
// (round-robin pick, packet counter, gap and timeout cycle arithmetic).
module tb_csi2tx_lane_pkt_scheduler;
  localparam int NUM_REQ = 4;
  localparam int GAP_W   = 8;
  localparam int TO_W    = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               tinit;
  logic               fstop;
  logic [NUM_REQ-1:0] empty;
  logic [2:0]         lane_cfg;
  logic [GAP_W-1:0]   gap_cfg;
  logic [TO_W-1:0]    to_cfg;
  logic               done;
  logic               idle;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         lane_en;
  logic               en_hs;
  logic               ldl_fs;
  logic               to_err;
  logic               busy;
  logic [15:0]        pkt_cnt;

  int total = 0;
  int bad   = 0;
  int rr_m  = NUM_REQ - 1;
  int pkts_m = 0;
  int lane_cur = 0;

  csi2tx_lane_pkt_scheduler #(.NUM_REQ(NUM_REQ), .GAP_W(GAP_W), .TO_W(TO_W)) dut (
    .txbyteclkhs            (clk),
    .txbyteclkhs_rst        (rst),
    .tinit_start            (tinit),
    .forcetxstopmode        (fstop),
    .req_fifo_empty         (empty),
    .lane_cfg               (lane_cfg),
    .gap_cfg                (gap_cfg),
    .timeout_cfg            (to_cfg),
    .ldl_tx_done            (done),
    .ldl_idle               (idle),
    .grant                  (grant),
    .lane_en                (lane_en),
    .enable_hs_transmission (en_hs),
    .ldl_force_stop         (ldl_fs),
    .timeout_err            (to_err),
    .sched_busy             (busy),
    .pkt_cnt                (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int ptr);
    int w;
    w = -1;
    for (int k = 1; k <= NUM_REQ; k++)
      if (w < 0 && req[(ptr + k) % NUM_REQ]) w = (ptr + k) % NUM_REQ;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant; reports grant-free cycles, IDLE cycles, and GAP cycles before IDLE.
  task automatic wait_grant(input string tag, output int zeros, output int lows, output int gapc);
    bit seen_low;
    seen_low = 1'b0;
    zeros = 0;
    lows  = 0;
    gapc  = 0;
    while (grant == '0 && zeros < 200) begin
      zeros++;
      if (!busy) begin
        lows++;
        seen_low = 1'b1;
      end else if (!seen_low) begin
        gapc++;
      end
      tick();
    end
    check({tag, "_granted"}, 32'(grant != '0), 32'd1);
  endtask

  task automatic check_grant(input string tag, input logic [NUM_REQ-1:0] req);
    int w;
    w = rr_pick(req, rr_m);
    check({tag, "_grant"}, 32'(grant), 32'(1) << w);
    check({tag, "_lane"}, 32'(lane_en), 32'(1) << lane_cur);
    rr_m = w;
  endtask

  // LDL side of a normal packet: done edge after act_wait cycles, ldl_idle after idle_wait.
  task automatic finish_pkt(input string tag, input int act_wait, input int idle_wait);
    logic [NUM_REQ-1:0] g;
    logic [7:0]         l;
    g = grant;
    l = lane_en;
    repeat (act_wait) tick();
    check({tag, "_hs_on"}, 32'(en_hs), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check({tag, "_hs_off"}, 32'(en_hs), 32'd0);
    repeat (idle_wait) tick();
    check({tag, "_drain_grant"}, 32'(grant), 32'(g));
    check({tag, "_drain_lane"}, 32'(lane_en), 32'(l));
    idle = 1'b1;
    tick();
    idle = 1'b0;
    pkts_m++;
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), pkts_m & 32'hFFFF);
    check({tag, "_grant_clr"}, 32'(grant), 32'd0);
    check({tag, "_lane_clr"}, 32'(lane_en), 32'd0);
  endtask

  initial begin
    int z, l, g, cyc, gap_r;
    logic [NUM_REQ-1:0] mask;

    rst = 1'b1; tinit = 1'b0; fstop = 1'b0; empty = '1; lane_cfg = '0;
    gap_cfg = '0; to_cfg = '0; done = 1'b0; idle = 1'b0;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_lane", 32'(lane_en), 32'd0);
    check("rst_hs", 32'(en_hs), 32'd0);
    check("rst_fs", 32'(ldl_fs), 32'd0);
    check("rst_toerr", 32'(to_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt", 32'(pkt_cnt), 32'd0);

    // 1: single source, two-cycle request-to-grant latency
    rst = 1'b0; tinit = 1'b1; lane_cfg = 3'd2; lane_cur = 2; empty = 4'b1110;
    tick();
    check("t1_arb_grant", 32'(grant), 32'd0);
    check("t1_arb_busy", 32'(busy), 32'd1);
    tick();
    check_grant("t1", 4'b0001);
    check("t1_hs", 32'(en_hs), 32'd1);
    empty = '1;
    lane_cfg = 3'd5;
    tick();
    check("t1_hold_grant", 32'(grant), 32'h1);
    check("t1_hold_lane", 32'(lane_en), 32'h04);
    finish_pkt("t1", 1, 1);

    // 2: all sources requesting, gap of 3
    gap_cfg = 8'd3; empty = '0;
    lane_cur = $urandom_range(0, 7); lane_cfg = 3'(lane_cur);
    for (int p = 0; p < 5; p++) begin
      wait_grant("t2", z, l, g);
      if (p > 0) begin
        check("t2_gap_cycles", 32'(g), 32'd3);
        check("t2_zero_grant", 32'(z), 32'd5);
        check("t2_idle_cycles", 32'(l), 32'd1);
      end
      check_grant("t2", 4'b1111);
      if (p == 4) empty = '1;
      finish_pkt("t2", $urandom_range(0, 3), $urandom_range(0, 2));
      lane_cur = $urandom_range(0, 7); lane_cfg = 3'(lane_cur);
    end

    // 3: timeout of 10 cycles, LDL never reports done
    gap_cfg = 8'd2; to_cfg = 16'd10;
    mask = 4'($urandom_range(1, 15)); empty = ~mask;
    wait_grant("t3", z, l, g);
    check_grant("t3", mask);
    empty = '1;
    to_cfg = 16'd3;
    cyc = 0;
    while (!to_err && cyc < 40) begin
      tick();
      cyc++;
    end
    check("t3_to_latency", 32'(cyc), 32'd10);
    check("t3_fs_on", 32'(ldl_fs), 32'd1);
    check("t3_hs_off", 32'(en_hs), 32'd0);
    check("t3_abort_grant", 32'(grant), 32'(1) << rr_m);
    tick();
    check("t3_to_pulse", 32'(to_err), 32'd0);
    repeat ($urandom_range(0, 3)) tick();
    check("t3_fs_hold", 32'(ldl_fs), 32'd1);
    idle = 1'b1;
    tick();
    idle = 1'b0;
    check("t3_fs_off", 32'(ldl_fs), 32'd0);
    check("t3_pkt_same", 32'(pkt_cnt), pkts_m & 32'hFFFF);
    check("t3_grant_clr", 32'(grant), 32'd0);
    check("t3_gap_busy", 32'(busy), 32'd1);
    to_cfg = '0;

    // 4: forcetxstopmode pulse mid-packet, then arbitration resumes after last winner
    empty = '0;
    wait_grant("t4", z, l, g);
    check_grant("t4", 4'b1111);
    tick();
    fstop = 1'b1;
    tick();
    fstop = 1'b0;
    check("t4_grant", 32'(grant), 32'd0);
    check("t4_lane", 32'(lane_en), 32'd0);
    check("t4_hs", 32'(en_hs), 32'd0);
    check("t4_fs", 32'(ldl_fs), 32'd0);
    check("t4_toerr", 32'(to_err), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    wait_grant("t4_next", z, l, g);
    check_grant("t4_next", 4'b1111);
    empty = '1;
    finish_pkt("t4", 0, 0);

    // tinit_start dropped in DRAIN together with ldl_idle: no count
    mask = 4'($urandom_range(1, 15)); empty = ~mask;
    wait_grant("t4b", z, l, g);
    check_grant("t4b", mask);
    empty = '1;
    done = 1'b1;
    tick();
    done = 1'b0; idle = 1'b1; tinit = 1'b0;
    tick();
    idle = 1'b0;
    check("t4b_pkt_same", 32'(pkt_cnt), pkts_m & 32'hFFFF);
    check("t4b_busy", 32'(busy), 32'd0);
    empty = '0;
    repeat (3) tick();
    check("t4b_no_start", 32'(busy), 32'd0);
    empty = '1; tinit = 1'b1;

    // 5: stale high done across packet start; lane_cfg change mid-packet
    gap_cfg = 8'd0; done = 1'b1;
    mask = 4'($urandom_range(1, 15)); empty = ~mask;
    wait_grant("t5", z, l, g);
    check_grant("t5", mask);
    empty = '1;
    repeat (3) tick();
    check("t5_stale_done", 32'(en_hs), 32'd1);
    lane_cfg = 3'(lane_cur + 3);
    tick();
    check("t5_lane_held", 32'(lane_en), 32'(1) << lane_cur);
    done = 1'b0;
    tick();
    check("t5_done_low", 32'(en_hs), 32'd1);
    finish_pkt("t5", 0, 1);

    // random masks, lane settings and gaps
    for (int i = 0; i < 8; i++) begin
      mask = 4'($urandom_range(1, 15)); empty = ~mask;
      lane_cur = $urandom_range(0, 7); lane_cfg = 3'(lane_cur);
      wait_grant("rnd", z, l, g);
      if (i > 0) begin
        check("rnd_gap_cycles", 32'(g), 32'(gap_r));
        check("rnd_zero_grant", 32'(z), 32'(gap_r + 2));
      end
      check_grant("rnd", mask);
      empty = '1;
      gap_r = $urandom_range(0, 3); gap_cfg = 8'(gap_r);
      finish_pkt("rnd", $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // 6: packet counter wrap with gap_cfg=0
    gap_cfg = 8'd0;
    repeat (6) tick();
    check("t6_idle", 32'(busy), 32'd0);
    force dut.pkt_cnt_q = 16'hFFFE;
    tick();
    @(negedge clk);
    release dut.pkt_cnt_q;
    tick();
    pkts_m = 32'hFFFE;
    check("t6_preload", 32'(pkt_cnt), 32'hFFFE);
    for (int i = 0; i < 2; i++) begin
      mask = 4'($urandom_range(1, 15)); empty = ~mask;
      wait_grant("t6", z, l, g);
      check_grant("t6", mask);
      empty = '1;
      finish_pkt("t6", 0, 0);
      check("t6_direct_idle", 32'(busy), 32'd0);
    end
    check("t6_wrapped", 32'(pkt_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
